// File: rtl/rgb_led_pkg.sv
// rtl/rgb_led_pkg.sv - shared types and constants for the RGB LED PWM fader
//
// Purpose: fader FSM state encoding, channel-to-LED mapping and the LED count.
// Ports: none (package).

package rgb_led_pkg;

  typedef enum logic [2:0] {
    STEADY   = 3'd0,
    FADE_OUT = 3'd1,
    FADE_IN  = 3'd2,
    BR_UP    = 3'd3,
    BR_DOWN  = 3'd4
  } fader_state_e;

  localparam int CH_RED   = 0;
  localparam int CH_GREEN = 1;
  localparam int CH_BLUE  = 2;

  localparam int NUM_LEDS = 3;

endpackage

// File: rtl/led_pwm_gen.sv
// rtl/led_pwm_gen.sv - N-channel PWM generator with glitch-free duty shadowing
//
// Purpose: free-running PWM counter; per-channel duty shadows that reload only
//          at the counter wrap; registered compare outputs.
// Ports:
//   clk      in   system clock
//   resetn   in   asynchronous active-low reset
//   duty     in   N packed duty values, channel i at [i*PWM_BITS +: PWM_BITS]
//   pwm_out  out  registered PWM outputs, one per channel

module led_pwm_gen #(
  parameter int PWM_BITS = 8,
  parameter int N        = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N*PWM_BITS-1:0] duty,
  output logic [N-1:0]          pwm_out
);

  localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_shadow [N];
  logic                wrap;

  // Shadows reload in the last cycle of a period so a new duty starts
  // cleanly at pwm_cnt == 0 and never chops a period mid-way.
  assign wrap = (pwm_cnt == '1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt <= '0;
      pwm_out <= '0;
      for (int i = 0; i < N; i++) begin
        duty_shadow[i] <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + CNT_ONE;
      for (int i = 0; i < N; i++) begin
        if (wrap) begin
          duty_shadow[i] <= duty[i*PWM_BITS +: PWM_BITS];
        end
        pwm_out[i] <= (pwm_cnt < duty_shadow[i]);
      end
    end
  end

endmodule

// File: rtl/rgb_led_pwm_fader.sv
// rtl/rgb_led_pwm_fader.sv - RGB channel indicator with PWM crossfade and breathe
//
// Purpose: shows the active audio channel on one of three LEDs, crossfading
//          out/in on channel change, with a brightness ceiling and an optional
//          breathe mode.
// Ports:
//   clk           in   system clock
//   resetn        in   asynchronous active-low reset
//   curr_channel  in   selected channel (0 red, 1 green, 2 blue, else off)
//   max_level     in   brightness ceiling
//   breathe_en    in   1 = breathe, 0 = steady
//   led_r/g/b     out  PWM LED drives
//   busy          out  high while crossfading

module rgb_led_pwm_fader
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int CH_W     = 3,
  parameter int STEP_DIV = 65536
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [CH_W-1:0]     curr_channel,
  input  logic [PWM_BITS-1:0] max_level,
  input  logic                breathe_en,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic                busy
);

  localparam int PRE_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);

  logic [PRE_W-1:0]             presc;
  logic                         tick;
  fader_state_e                 state, state_next;
  logic [PWM_BITS-1:0]          level, level_next;
  logic [CH_W-1:0]              active_ch, active_ch_next;
  logic                         ch_diff;
  logic [NUM_LEDS*PWM_BITS-1:0] duty;
  logic [NUM_LEDS-1:0]          pwm_out;

  // Brightness step timebase.
  assign tick = (presc == PRE_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRE_ONE;
    end
  end

  assign ch_diff = (curr_channel != active_ch);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= FADE_IN;
      level     <= '0;
      active_ch <= '0;
    end else begin
      state     <= state_next;
      level     <= level_next;
      active_ch <= active_ch_next;
    end
  end

  // Channel change outranks breathe changes, which outrank level stepping.
  always_comb begin
    state_next     = state;
    level_next     = level;
    active_ch_next = active_ch;
    case (state)
      STEADY: begin
        if (ch_diff) begin
          state_next = FADE_OUT;
        end else if (breathe_en) begin
          state_next = BR_UP;
        end else if (tick) begin
          if (level < max_level) begin
            level_next = level + LVL_ONE;
          end else if (level > max_level) begin
            level_next = level - LVL_ONE;
          end
        end
      end
      FADE_OUT: begin
        // The fade always runs to dark; only the channel selected at that
        // moment is adopted, so mid-fade toggling cannot abort it.
        if (level == '0) begin
          active_ch_next = curr_channel;
          state_next     = breathe_en ? BR_UP : FADE_IN;
        end else if (tick) begin
          level_next = level - LVL_ONE;
        end
      end
      FADE_IN: begin
        if (ch_diff) begin
          state_next = FADE_OUT;
        end else if (level >= max_level) begin
          state_next = STEADY;
        end else if (tick) begin
          level_next = level + LVL_ONE;
        end
      end
      BR_UP: begin
        if (ch_diff) begin
          state_next = FADE_OUT;
        end else if (!breathe_en) begin
          state_next = STEADY;
        end else if (level >= max_level) begin
          // >= also catches a ceiling lowered below the current level.
          state_next = BR_DOWN;
        end else if (tick) begin
          level_next = level + LVL_ONE;
        end
      end
      BR_DOWN: begin
        if (ch_diff) begin
          state_next = FADE_OUT;
        end else if (!breathe_en) begin
          state_next = STEADY;
        end else if (level == '0) begin
          state_next = BR_UP;
        end else if (tick) begin
          level_next = level - LVL_ONE;
        end
      end
      default: begin
        state_next = FADE_IN;
      end
    endcase
  end

  // Only the active component is lit; out-of-range channels leave all dark.
  always_comb begin
    duty = '0;
    if (active_ch == CH_W'(CH_RED)) begin
      duty[CH_RED*PWM_BITS +: PWM_BITS] = level;
    end else if (active_ch == CH_W'(CH_GREEN)) begin
      duty[CH_GREEN*PWM_BITS +: PWM_BITS] = level;
    end else if (active_ch == CH_W'(CH_BLUE)) begin
      duty[CH_BLUE*PWM_BITS +: PWM_BITS] = level;
    end
  end

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS),
    .N        (NUM_LEDS)
  ) u_pwm (
    .clk     (clk),
    .resetn  (resetn),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

  assign led_r = pwm_out[CH_RED];
  assign led_g = pwm_out[CH_GREEN];
  assign led_b = pwm_out[CH_BLUE];

  // Gated by resetn so busy reads low while reset is held even though the
  // reset state is FADE_IN.
  assign busy = resetn && ((state == FADE_OUT) || (state == FADE_IN));

endmodule

// File: doc/rgb_led_pwm_fader.md
Name: rgb_led_pwm_fader

Overview:
Parametrised successor to the fixed 50 % RGB channel indicator. Drives led_r/led_g/led_b with a configurable-resolution PWM and a run-time brightness ceiling. Crossfades out and in whenever curr_channel changes, and offers an optional continuous "breathe" mode. Sits beside the audio channel selector and gives visual feedback of the active channel.

Parameters:
PWM_BITS, 8, PWM counter and brightness resolution; PWM period = 2^PWM_BITS clk cycles.
CH_W, 3, width of curr_channel.
STEP_DIV, 65536, clk cycles per brightness step tick (>=2).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-low reset
curr_channel  in  CH_W  selected channel; 0=red, 1=green, 2=blue, any other value = all LEDs off
max_level  in  PWM_BITS  brightness ceiling (duty target)
breathe_en  in  1  1 = breathe mode, 0 = steady
led_r  out  1  red PWM output
led_g  out  1  green PWM output
led_b  out  1  blue PWM output
busy  out  1  high while a crossfade is in progress (state FADE_OUT or FADE_IN)

Behaviour:
- Reset (async, resetn=0): all LEDs 0, busy 0, pwm_cnt 0, prescaler 0, level 0, active_ch 0, all duty shadows 0, state FADE_IN.
- pwm_cnt: free-running PWM_BITS counter, wraps at 2^PWM_BITS-1 -> 0.
- Prescaler: counts 0..STEP_DIV-1 and pulses tick for one cycle when it wraps. All level changes happen only on tick cycles, by exactly ±1 per tick, and never overflow or underflow.
- Duty: the active component (the one selected by active_ch) gets duty = level; the other two get 0. If active_ch > 2, all three duties are 0.
- Duty shadow registers load only in the cycle where pwm_cnt == all-ones, so a new duty takes effect from pwm_cnt == 0 and no glitches are produced.
- Outputs are registered: led_x <= (pwm_cnt < duty_shadow_x), giving 1 cycle of latency. duty 0 means always low; the maximum duty gives high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- Channel change: ch_diff = (curr_channel != active_ch).
- FSM states: STEADY, FADE_OUT, FADE_IN, BR_UP, BR_DOWN. Priority, highest first: ch_diff, then breathe_en change, then level stepping.
  - STEADY: ch_diff -> FADE_OUT. Else breathe_en -> BR_UP. Else on tick, level moves one step toward max_level (up or down); it holds when equal.
  - FADE_OUT: on tick, level decrements. When level == 0 (checked every cycle), active_ch <= curr_channel sampled in that cycle, then go to BR_UP if breathe_en, else FADE_IN. curr_channel changes during FADE_OUT, including a return to the old channel, do not abort the fade; only the value at level 0 is used.
  - FADE_IN: ch_diff -> FADE_OUT. Else if level >= max_level -> STEADY. Else on tick, level increments.
  - BR_UP: ch_diff -> FADE_OUT. Else !breathe_en -> STEADY. Else if level >= max_level -> BR_DOWN (covers max_level being lowered below level). Else on tick, level increments.
  - BR_DOWN: ch_diff -> FADE_OUT. Else !breathe_en -> STEADY. Else if level == 0 -> BR_UP. Else on tick, level decrements.
- max_level = 0: FADE_IN exits to STEADY at once. Breathe alternates between BR_UP and BR_DOWN each cycle with level held at 0 and LEDs dark.
- busy is a combinational decode of the state.
- Reset asserted mid-fade: immediate return to reset values. After release, power-up behaviour is a fade-in to max_level; if curr_channel != 0 it first passes through FADE_OUT, which completes at once because level is already 0.

Decomposition:
- Package rgb_led_pkg holds:
  - state encoding (STEADY, FADE_OUT, FADE_IN, BR_UP, BR_DOWN);
  - channel constants CH_RED=0, CH_GREEN=1, CH_BLUE=2.
- Sub-module led_pwm_gen #(PWM_BITS, N=3) contains pwm_cnt, the duty shadow registers with their load-at-wrap logic, and the registered compare outputs.
- The top level holds the prescaler, the FSM, level, active_ch, and the duty mux.

Test Plan:
- Common settings: PWM_BITS=4, STEP_DIV=4.
- Reset release with curr_channel=0, max_level=8, breathe_en=0 -> level climbs 0..8 with one step per 4 cycles, busy=1 until STEADY. Then led_r is high for 8 of 16 cycles per period; led_g and led_b stay 0.
- In STEADY at level 8, switch curr_channel 0->2 -> busy=1, red duty steps 8->0. Blue appears only after level reaches 0, then ramps to 8 and busy drops. At no point is more than one LED lit.
- During FADE_OUT, toggle curr_channel 2->1->0 -> the fade runs to 0 regardless, active_ch=0 (the value at level 0), and red ramps back in.
- breathe_en=1 with max_level=3 -> level follows 0,1,2,3,2,1,0,1,... with one step per tick. Setting breathe_en=0 at level 1 -> STEADY, and level climbs to 3.
- curr_channel=5 -> crossfade to all-off; all LEDs stay 0 and busy clears after the fade-in completes.
- Assert resetn mid-FADE_IN at level 5 -> all outputs are 0 in the same cycle (asynchronous). On release, level restarts at 0. A duty change mid-period takes effect only at the pwm_cnt wrap.
